snake_dir_ctrl: RTL
===================

// Module: snake_dir_ctrl
// PURPOSE
//  Consumes the one-cycle key-press pulses from the key debouncer and turns them
//  into the snake's movement direction.
//  Presses are filtered against reversal and repeats, then buffered in a small
//  FIFO. One queued turn is applied per game step tick. Sits between the key
//  debouncer and the snake motion/collision logic.
// PARAMETERS
//  QDEPTH    2      turn-queue depth, legal 1..4
//  INIT_DIR  2'b11  direction after reset (encoding: 00 up, 01 down, 10 left, 11 right)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous reset, active-high
//  en         in   1  game running; low = presses and steps ignored, state held
//  up_press   in   1  one-cycle press pulse, up
//  down_press in   1  one-cycle press pulse, down
//  left_press in   1  one-cycle press pulse, left
//  right_press in  1  one-cycle press pulse, right
//  step       in   1  one-cycle game-tick pulse; snake advances one cell
//  dir        out  2  current movement direction (registered)
//  turn       out  1  one-cycle pulse: dir changed on this cycle
//  drop       out  1  one-cycle pulse: a press was rejected
//  q_count    out  3  number of queued turns, 0..QDEPTH
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge clk): dir=INIT_DIR, queue empty, q_count=0,
//    turn=0, drop=0. Reset wins over every other input, including mid-queue.
//  - Press decode, per cycle: exactly one press input high = valid request.
//    Two or more high in the same cycle = rejected, drop=1. None high = nothing.
//  - Reference direction REF = newest queued entry if q_count>0, else dir.
//    REF is sampled before any pop in the same cycle.
//  - Valid request rejected with drop=1 when:
//    (a) it equals REF (repeat),
//    (b) it is the opposite of REF (up/down, left/right reversal),
//    (c) the queue is full, q_count==QDEPTH, evaluated before the same-cycle pop.
//  - A valid request passing all three checks is pushed at the tail.
//  - Step: if step=1 and q_count>0, the head is popped into dir. The new dir is
//    visible the cycle after step, with turn=1 in that same cycle.
//    If step=1 and the queue is empty: dir holds, turn=0.
//  - Push and pop in the same cycle: both happen and q_count is unchanged.
//    A push into an empty queue on a step cycle is not applied by that step; it
//    waits for the next step.
//  - en=0: press pulses and step are ignored (no push, no pop, no drop). Queue
//    and dir are held. turn and drop are 0 the cycle after any cycle with en=0.
//  - turn and drop are registered and high for exactly one cycle per event.
//  - Queue is a circular buffer. Read/write pointers wrap modulo QDEPTH.
//    q_count is tracked separately, so full and empty are distinguished.
//  - Latency:
//    press -> q_count update: 1 cycle.
//    step -> dir/turn: 1 cycle.
//    press -> drop: 1 cycle.
// TESTING
//  1 Reset, then step pulses with no presses -> dir=2'b11 throughout, turn never 1, q_count=0.
//  2 dir=right: up_press, then step -> q_count=1; after step, dir=00 with turn=1 for one cycle, q_count=0.
//  3 dir=right: left_press -> drop=1, q_count=0; right_press -> drop=1; dir stays 11.
//  4 QDEPTH=2, dir=right: up, left, down presses, no step -> first two queued
//    (q_count=2); down dropped as full; two steps -> dir 00 then 10.
//  5 q_count=1 (queued up), dir=right: press left in the same cycle as step ->
//    pop gives dir=00; left checked against REF=up, queued, q_count=1; next step -> dir=10.
//  6 up_press+left_press same cycle -> drop=1. Then en=0 with presses and steps -> no change.
//    Then rst=1 with queue non-empty -> next cycle dir=11, q_count=0.

Source files
------------

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: filters key presses into a small turn queue
// and applies one queued turn per game step tick.
module snake_dir_ctrl #(
  parameter int         QDEPTH   = 2,
  parameter logic [1:0] INIT_DIR = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up_press,
  input  logic       down_press,
  input  logic       left_press,
  input  logic       right_press,
  input  logic       step,
  output logic [1:0] dir,
  output logic       turn,
  output logic       drop,
  output logic [2:0] q_count
);

  localparam logic [1:0] LAST = 2'(QDEPTH - 1);
  localparam logic [2:0] FULL = 3'(QDEPTH);

  logic [1:0] r_q [4];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_cnt;
  logic [1:0] r_dir;
  logic       r_turn;
  logic       r_drop;

  logic [2:0] w_npress;
  logic       w_one;
  logic       w_multi;
  logic [1:0] w_req;
  logic [1:0] w_tail;
  logic [1:0] w_ref;
  logic       w_axis_ok;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_reject;
  logic [1:0] w_wptr_nx;
  logic [1:0] w_rptr_nx;

  // Press decode: count simultaneous presses, encode the single one
  always_comb begin
    w_npress = {2'b00, up_press} + {2'b00, down_press}
             + {2'b00, left_press} + {2'b00, right_press};
    w_one    = (w_npress == 3'd1);
    w_multi  = (w_npress > 3'd1);
    w_req    = {left_press | right_press, down_press | right_press};
  end

  // Reference direction and accept/reject decision for the request
  always_comb begin
    w_tail    = (r_wptr == 2'd0) ? LAST : r_wptr - 2'd1;
    w_empty   = (r_cnt == 3'd0);
    w_full    = (r_cnt == FULL);
    w_ref     = w_empty ? r_dir : r_q[w_tail];
    // Repeat and reversal both stay on the same axis (bit 1)
    w_axis_ok = (w_req[1] != w_ref[1]);
    w_push    = en & w_one & w_axis_ok & ~w_full;
    w_pop     = en & step & ~w_empty;
    w_reject  = en & (w_multi | (w_one & ~w_push));
  end

  // Circular pointer advance, wrapping at QDEPTH
  always_comb begin
    w_wptr_nx = (r_wptr == LAST) ? 2'd0 : r_wptr + 2'd1;
    w_rptr_nx = (r_rptr == LAST) ? 2'd0 : r_rptr + 2'd1;
  end

  // Queue storage, pointers, count, direction and event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_q[i] <= 2'b00;
      r_wptr <= 2'd0;
      r_rptr <= 2'd0;
      r_cnt  <= 3'd0;
      r_dir  <= INIT_DIR;
      r_turn <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (w_push) begin
        r_q[r_wptr] <= w_req;
        r_wptr      <= w_wptr_nx;
      end
      if (w_pop) begin
        r_dir  <= r_q[r_rptr];
        r_rptr <= w_rptr_nx;
      end
      if (w_push && !w_pop) r_cnt <= r_cnt + 3'd1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 3'd1;
      r_turn <= w_pop;
      r_drop <= w_reject;
    end
  end

  assign dir     = r_dir;
  assign turn    = r_turn;
  assign drop    = r_drop;
  assign q_count = r_cnt;

endmodule
